l2_arbiter_64: RTL
==================

L2_ARBITER_64 -- requirements
Module: l2_arbiter_64

Interface
REQ-001 Parameters SHALL be exactly as follows.
- TIMEOUT, 15, maximum WAIT cycles before abort.
REQ-002 Ports SHALL be exactly as follows.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  4  per-core L2 access request; bit i = core i.
- req_wr  in  4  per-core access type; 1 = write-through, 0 = read miss.
- req_st  in  128  per-core 32-bit address; core i in bits [32i+31:32i].
- req_data  in  256  per-core 64-bit write data; core i in bits [64i+63:64i].
- gnt  out  4  one-hot owner of the L2 port.
- done  out  4  one-cycle completion pulse to the owner.
- err  out  1  high with done when the access timed out.
- rd_data  out  64  read return data, valid with done.
- l2_valid  out  1  L2 command valid.
- l2_mode  out  2  L2 command: 00 read, 11 write, 01 idle.
- l2_st  out  32  L2 address.
- l2_in  out  64  L2 write data.
- l2_proin  out  2  index of the issuing core.
- l2_ready  in  1  L2 accepts the command; read data valid this cycle.
- l2_out  in  64  L2 read data.
- l2_sprocinfo  in  4  sharer vector, valid with l2_ready.
- coh_valid  out  4  one-cycle coherency-update strobe per L1.
- coh_st  out  32  coherency-update address.
- coh_data  out  64  coherency-update data.

Function
REQ-003 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT, COH, RESP.
REQ-004 IDLE with req != 0 SHALL pick a winner round-robin, starting at last_gnt+1 mod 4.
- Latch the winner's index, req_wr, req_st and req_data.
- Next state is ISSUE.
REQ-005 ISSUE SHALL drive l2_valid=1 with the latched command, for one cycle.
- l2_mode: 11 if write, else 00.
- l2_st, l2_in and l2_proin from the latched fields.
- Next state is WAIT.
REQ-006 WAIT SHALL hold the command until l2_ready=1.
- An l2_ready already high in ISSUE counts as the accept.
REQ-007 On accept of a read, the block SHALL capture l2_out and go to RESP.
REQ-008 On accept of a write, the block SHALL capture mask = l2_sprocinfo with the owner's bit cleared.
- Go to COH if mask != 0, otherwise to RESP.
REQ-009 COH SHALL pulse coh_valid=mask for one cycle, with coh_st/coh_data equal to the latched address/data, then go to RESP.
REQ-010 RESP SHALL pulse done[owner]=1 and rd_data for one cycle, update last_gnt=owner, and return to IDLE.
- rd_data is the captured l2_out for a read and 0 for a write.
REQ-011 gnt SHALL equal the one-hot owner from ISSUE through RESP, and 0 in IDLE.
REQ-012 Timeout: after TIMEOUT WAIT cycles without l2_ready, the block SHALL go to RESP with err=1, rd_data=all-ones, and no COH.
REQ-013 Latency: a request seen in IDLE at cycle N SHALL give l2_valid at N+1.
- Earliest done is N+2 (read, or write without sharers).
- Earliest done is N+3 (write with sharers).
REQ-014 Deasserting req mid-transaction SHALL NOT abort the transaction; done still pulses.
REQ-015 A req held high after done SHALL be re-arbitrated normally, so other pending cores go first.
REQ-016 With all four requesting continuously, grant order SHALL be 0,1,2,3,0,...
REQ-017 Outside ISSUE/WAIT, l2_valid SHALL be 0 and l2_mode 01.
REQ-018 Only one transaction SHALL be outstanding; new requests SHALL NOT be sampled outside IDLE.

Reset
REQ-019 On rst=1 at a clock edge, the block SHALL enter IDLE from any state.
- Set last_gnt=3 and clear the timeout counter.
- Drive gnt, done, err, rd_data, l2_valid, l2_st, l2_in, l2_proin, coh_valid, coh_st and coh_data to 0, and l2_mode to 01.
- An in-flight transaction is dropped with no done.

Structure
REQ-020 Package l2_arb_pkg SHALL hold the following.
- State enum.
- MODE_RD=2'b00, MODE_WR=2'b11, MODE_IDLE=2'b01.
- NCORE=4.
REQ-021 Round-robin selection SHALL live in sub-module rr_pick4 (req[3:0], last_gnt[1:0] -> winner index, any).

Verification
REQ-022 The bench SHALL cover these scenarios.
- Read: core 2 reads st=32'h0000_1111, l2_ready next cycle, l2_out=64'hF -> l2_proin=10, done=4'b0100, rd_data=64'hF.
- Write with sharers: core 0 writes 64'hE to 32'h1001_0010, sprocinfo=4'b1011 -> coh_valid=4'b1010 for one cycle, coh_data=64'hE, then done=4'b0001.
- Fairness: req=4'b1111 held after reset -> grants 0,1,2,3,0.
- Timeout: l2_ready held 0 -> done with err=1 and rd_data=64'hFFFF_FFFF_FFFF_FFFF after 15 WAIT cycles.
- Reset in WAIT -> next cycle IDLE, gnt=0, no done; next request served with core 0 first.

Source files
------------

// File: rtl/l2_arb_pkg.sv
// l2_arb_pkg
// Shared definitions for the four-core L2 port arbiter:
//   state_t   - arbiter FSM states
//   MODE_*    - encodings driven on l2_mode
//   NCORE     - number of requesting cores
//   onehot()  - core index to one-hot grant vector
package l2_arb_pkg;

    localparam int NCORE = 4;

    localparam logic [1:0] MODE_RD   = 2'b00;
    localparam logic [1:0] MODE_WR   = 2'b11;
    localparam logic [1:0] MODE_IDLE = 2'b01;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        COH   = 3'd3,
        RESP  = 3'd4
    } state_t;

    function automatic logic [NCORE-1:0] onehot(input logic [1:0] idx);
        logic [NCORE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rr_pick4
// Round-robin pick among four requesters. The search starts at the core
// after the previous owner and wraps, so the previous owner is checked last.
// Ports:
//   req      in   4  request vector, bit i = core i
//   last_gnt in   2  index of the previous owner
//   winner   out  2  index of the selected core (last_gnt when none)
//   any      out  1  at least one request present
module rr_pick4
    import l2_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_gnt,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] cand;

    always_comb begin
        winner = last_gnt;
        any    = 1'b0;
        cand   = '0;
        // Offsets 1..4 visit last_gnt+1 first and last_gnt itself last.
        for (int i = 1; i <= NCORE; i++) begin
            cand = last_gnt + 2'(i);
            if (!any && req[cand]) begin
                winner = cand;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l2_arbiter_64.sv
// l2_arbiter_64
// Arbitrates four cores onto a single L2 command port, one transaction at a
// time. A write-through whose sharer vector names other L1s triggers a
// one-cycle coherency-update broadcast before completion.
//
// Handshake: l2_valid is held with a stable command (l2_mode, l2_st, l2_in,
// l2_proin) from ISSUE until the cycle l2_ready is sampled high; that cycle
// is the accept, and l2_out / l2_sprocinfo are taken from the same cycle.
// If no accept arrives within TIMEOUT WAIT cycles the command is abandoned
// and the owner is completed with err=1.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req/req_wr         per-core request and access type (1 = write)
//   req_st/req_data    per-core 32-bit address / 64-bit write data
//   gnt                one-hot owner, ISSUE through RESP
//   done/err/rd_data   one-cycle completion to the owner
//   l2_valid/l2_mode/l2_st/l2_in/l2_proin   L2 command
//   l2_ready/l2_out/l2_sprocinfo            L2 accept, read data, sharers
//   coh_valid/coh_st/coh_data               coherency-update strobe
//
// The FSM state is held in state_q for observation by checkers.
module l2_arbiter_64
    import l2_arb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [3:0]   req_wr,
    input  logic [127:0] req_st,
    input  logic [255:0] req_data,
    output logic [3:0]   gnt,
    output logic [3:0]   done,
    output logic         err,
    output logic [63:0]  rd_data,
    output logic         l2_valid,
    output logic [1:0]   l2_mode,
    output logic [31:0]  l2_st,
    output logic [63:0]  l2_in,
    output logic [1:0]   l2_proin,
    input  logic         l2_ready,
    input  logic [63:0]  l2_out,
    input  logic [3:0]   l2_sprocinfo,
    output logic [3:0]   coh_valid,
    output logic [31:0]  coh_st,
    output logic [63:0]  coh_data
);

    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t         state_q;
    state_t         state_d;

    logic [1:0]     last_gnt_q;
    logic [1:0]     owner_q;
    logic           wr_q;
    logic [31:0]    st_q;
    logic [63:0]    data_q;
    logic [3:0]     mask_q;
    logic [63:0]    resp_q;
    logic           err_q;
    logic [TW-1:0]  tcnt_q;

    logic [1:0]     pick_idx;
    logic           pick_any;
    logic [3:0]     owner_oh;
    logic [3:0]     coh_mask;
    logic           in_cmd;
    logic           tout;

    rr_pick4 u_pick (
        .req      (req),
        .last_gnt (last_gnt_q),
        .winner   (pick_idx),
        .any      (pick_any)
    );

    assign owner_oh = onehot(owner_q);
    // The owner never needs an update for its own write.
    assign coh_mask = l2_sprocinfo & ~owner_oh;
    assign in_cmd   = (state_q == ISSUE) || (state_q == WAIT);
    // Last WAIT cycle without an accept.
    assign tout     = (state_q == WAIT) && !l2_ready && (tcnt_q == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and outputs. Every output is gated by state, so IDLE (and
    // therefore reset) presents an all-zero interface with l2_mode idle.
    always_comb begin
        state_d   = state_q;
        gnt       = '0;
        done      = '0;
        err       = 1'b0;
        rd_data   = '0;
        l2_valid  = 1'b0;
        l2_mode   = MODE_IDLE;
        l2_st     = '0;
        l2_in     = '0;
        l2_proin  = '0;
        coh_valid = '0;
        coh_st    = '0;
        coh_data  = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                gnt      = owner_oh;
                l2_valid = 1'b1;
                l2_mode  = wr_q ? MODE_WR : MODE_RD;
                l2_st    = st_q;
                l2_in    = data_q;
                l2_proin = owner_q;
                if (l2_ready) begin
                    state_d = (wr_q && (coh_mask != 4'b0000)) ? COH : RESP;
                end else if (state_q == ISSUE) begin
                    state_d = WAIT;
                end else if (tout) begin
                    state_d = RESP;
                end
            end
            COH: begin
                gnt       = owner_oh;
                coh_valid = mask_q;
                coh_st    = st_q;
                coh_data  = data_q;
                state_d   = RESP;
            end
            RESP: begin
                gnt     = owner_oh;
                done    = owner_oh;
                err     = err_q;
                rd_data = resp_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction datapath: latched command, accept capture, timeout count.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= 2'd3;
            owner_q    <= '0;
            wr_q       <= 1'b0;
            st_q       <= '0;
            data_q     <= '0;
            mask_q     <= '0;
            resp_q     <= '0;
            err_q      <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        owner_q <= pick_idx;
                        wr_q    <= req_wr[pick_idx];
                        st_q    <= req_st[32*pick_idx +: 32];
                        data_q  <= req_data[64*pick_idx +: 64];
                    end
                    mask_q <= '0;
                    resp_q <= '0;
                    err_q  <= 1'b0;
                    tcnt_q <= '0;
                end
                ISSUE, WAIT: begin
                    if (l2_ready) begin
                        // Writes return zero data; only reads keep l2_out.
                        resp_q <= wr_q ? 64'd0 : l2_out;
                        mask_q <= wr_q ? coh_mask : 4'b0000;
                    end else if (tout) begin
                        resp_q <= '1;
                        err_q  <= 1'b1;
                    end else if (state_q == WAIT) begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                RESP: begin
                    last_gnt_q <= owner_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
